cpu_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the 8-bit processor datapath (8x8 register file, 2's-complement
//  and immediate muxes, 4-function ALU). Owns the program counter, fetches 32-bit instructions over
//  a req/ack instruction-memory port and holds them in its instruction register. Steps each one

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/seq_pc_unit.sv | 31 +++
 rtl/cpu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle sequencer:
// opcodes, state/fault/ALU encodings and instruction field positions.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_JUMP  = 8'h04;
    localparam logic [7:0] OP_MOV   = 8'h08;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int OPC_LSB    = 24;
    localparam int ALU_LSB    = 24;
    localparam int WADDR_LSB  = 16;
    localparam int JOFS_LSB   = 16;
    localparam int RADDR2_LSB = 8;
    localparam int RADDR1_LSB = 0;
    localparam int IMM_LSB    = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_ILLEGAL = 2'b01,
        FLT_TIMEOUT = 2'b10
    } fault_t;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_t;

    function automatic logic op_is_alu(input logic [7:0] op);
        return op inside {OP_LOADI, OP_ADD, OP_AND,
                          OP_OR, OP_MOV, OP_SUB};
    endfunction

    function automatic logic op_is_legal(input logic [7:0] op);
        return op_is_alu(op) || op == OP_JUMP || op == OP_HALT;
    endfunction

endpackage

// File: rtl/seq_pc_unit.sv
// Program counter: sequential step and PC-relative jump target.
// Jump target is relative to the sequential next PC, word-scaled.
module seq_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_en,
    input  logic        jump_en,
    input  logic [7:0]  offset,
    output logic [31:0] pc
);

    logic [31:0] pc_inc;
    logic [31:0] jump_tgt;

    assign pc_inc   = pc + 32'(PC_STEP);
    assign jump_tgt = pc_inc + {{22{offset[7]}}, offset, 2'b00};

    // PC register: jump takes priority over a plain step
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else if (jump_en)
            pc <= jump_tgt;
        else if (step_en)
            pc <= pc_inc;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the
// 8-bit datapath: fetch port, IR, decode, fault and retire tracking.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter int          PC_STEP       = 4,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    output logic [2:0]  rf_waddr,
    output logic        rf_we,
    output logic [7:0]  imm,
    output logic        imm_sel,
    output logic        neg_sel,
    output logic [2:0]  alu_select,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [15:0] retired
);

    localparam int TW = $clog2(FETCH_TIMEOUT + 1);

    state_t        state_q, state_d;
    fault_t        fault_q, fault_d;
    logic [31:0]   ir_q;
    logic [31:0]   pc;
    logic [TW-1:0] timer_q;
    logic [15:0]   retired_q;
    logic [7:0]    op;
    logic          ir_load;
    logic          pc_step;
    logic          pc_jump;
    logic          retire;
    logic          is_jump;
    logic          timed_out;
    logic          unused_ir;

    assign op        = ir_q[OPC_LSB +: 8];
    assign is_jump   = (op == OP_JUMP);
    assign timed_out = (timer_q == TW'(FETCH_TIMEOUT));
    assign unused_ir = ^ir_q[15:11];

    seq_pc_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .step_en (pc_step),
        .jump_en (pc_jump),
        .offset  (ir_q[JOFS_LSB +: 8]),
        .pc      (pc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Fetch wait timer: reads 1 in the first FETCH cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer_q <= TW'(1);
        else if (state_q != S_FETCH)
            timer_q <= TW'(1);
        else
            timer_q <= timer_q + TW'(1);
    end

    // Instruction register, loaded on the acked fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir_q <= '0;
        else if (ir_load)
            ir_q <= imem_rdata;
    end

    // Sticky fault code and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q   <= FLT_NONE;
            retired_q <= '0;
        end else begin
            fault_q <= fault_d;
            if (retire)
                retired_q <= retired_q + 16'd1;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        ir_load = 1'b0;
        pc_step = 1'b0;
        pc_jump = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    fault_d = FLT_TIMEOUT;
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (!op_is_legal(op)) begin
                    fault_d = FLT_ILLEGAL;
                    state_d = S_FAULT;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_jump = is_jump;
                state_d = S_WB;
            end
            S_WB: begin
                pc_step = !is_jump;
                retire  = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc;
    assign rf_raddr1  = ir_q[RADDR1_LSB +: 3];
    assign rf_raddr2  = ir_q[RADDR2_LSB +: 3];
    assign rf_waddr   = ir_q[WADDR_LSB +: 3];
    assign imm        = ir_q[IMM_LSB +: 8];
    assign alu_select = ir_q[ALU_LSB +: 3];
    assign imm_sel    = (op != OP_LOADI);
    assign neg_sel    = (op == OP_SUB);
    assign rf_we      = (state_q == S_WB) && op_is_alu(op);
    assign busy       = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
    assign halted     = (state_q == S_HALT);
    assign fault      = fault_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction memory responder,
// datapath model, per-cycle behavioural model and directed scenarios.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we, imm_sel, neg_sel, busy, halted;
    logic [7:0]  imm;
    logic [2:0]  alu_select;
    logic [1:0]  fault;
    logic [15:0] retired;
    logic [75:0] allout;

    cpu_sequencer #(
        .RESET_PC      (32'd0),
        .PC_STEP       (4),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .imm        (imm),
        .imm_sel    (imm_sel),
        .neg_sel    (neg_sel),
        .alu_select (alu_select),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    assign allout = {imem_req, imem_addr, rf_raddr1, rf_raddr2,
                     rf_waddr, rf_we, imm, imm_sel, neg_sel,
                     alu_select, busy, halted, fault, retired};

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- instruction memory responder ----------------
    logic [31:0] mem [256];
    int fixed_delay = 0;
    int ack_delay = 0;
    int wcnt = 0;

    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (wcnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[9:2]];
                wcnt       = 0;
                ack_delay  = (fixed_delay < 0) ?
                             int'($urandom_range(0, 3)) : fixed_delay;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            wcnt       = 0;
            imem_ack   = ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
        end
    end

    // ---------------- datapath model (regfile + ALU) ----------------
    logic [7:0] rf [8];

    function automatic logic [7:0] dp_res();
        logic [7:0] d0, s, d1;
        d0 = rf[rf_raddr2];
        s  = rf[rf_raddr1];
        d1 = imm_sel ? (neg_sel ? 8'(-s) : s) : imm;
        case (alu_select)
            3'b000:  return d1;
            3'b001:  return d0 + d1;
            3'b010:  return d0 & d1;
            3'b011:  return d0 | d1;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        end else if (rf_we) begin
            rf[rf_waddr] = dp_res();
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] m_ir, m_pc;
    logic [7:0]  m_op;
    int m_ret, m_fault, m_wait, m_age;
    bit m_idle, m_halt;

    function automatic bit is_alu(input logic [7:0] o);
        return o inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_pc = 0; m_ir = 0; m_ret = 0; m_fault = 0;
            m_wait = 0; m_age = 0; m_idle = 1; m_halt = 0;
        end else begin
            m_op = m_ir[31:24];
            chk("m_req", imem_req, m_wait > 0);
            if (m_wait > 0) chk("m_addr", imem_addr, m_pc);
            chk("m_busy", busy, !(m_idle || m_halt || m_fault != 0));
            chk("m_halted", halted, m_halt);
            chk("m_fault", fault, m_fault);
            chk("m_retired", retired, m_ret);
            chk("m_rf_we", rf_we, m_age == 3 && is_alu(m_op));
            if (m_age > 0)
                chk("m_ctl",
                    {rf_raddr1, rf_raddr2, rf_waddr, imm,
                     imm_sel, neg_sel, alu_select},
                    {m_ir[2:0], m_ir[10:8], m_ir[18:16], m_ir[7:0],
                     m_op != 8'h00, m_op == 8'h09, m_ir[26:24]});
            // advance to what the next cycle must show
            if (m_halt || m_fault != 0) begin
                m_wait = 0;
            end else if (m_idle) begin
                if (run) begin m_idle = 0; m_wait = 1; end
            end else if (m_wait > 0) begin
                if (imem_ack) begin
                    m_ir = imem_rdata; m_wait = 0; m_age = 1;
                end else if (m_wait == 16) begin
                    m_fault = 2; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else if (m_age == 1) begin
                if (!(is_alu(m_op) || m_op == 8'h04 || m_op == 8'hFF))
                    begin m_fault = 1; m_age = 0; end
                else if (m_op == 8'hFF)
                    begin m_halt = 1; m_age = 0; end
                else
                    m_age = 2;
            end else if (m_age == 2) begin
                if (m_op == 8'h04)
                    m_pc = m_pc + 32'd4 +
                           {{22{m_ir[23]}}, m_ir[23:16], 2'b00};
                m_age = 3;
            end else begin
                if (m_op != 8'h04) m_pc = m_pc + 32'd4;
                m_ret = (m_ret + 1) & 16'hFFFF;
                m_age = 0;
                if (run) m_wait = 1; else m_idle = 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic set_delay(input int d);
        fixed_delay = d;
        ack_delay = (d < 0) ? int'($urandom_range(0, 3)) : d;
    endtask

    task automatic fill_mem(input logic [31:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start;
        @(posedge clk);
        #1 run = 1'b1;
    endtask

    task automatic wait_ack(output logic [31:0] addr);
        bit got;
        got = 0;
        addr = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                got = 1;
                addr = imem_addr;
            end
        end
        if (!got) begin
            nchk++; nerr++;
            $display("FAIL wait_ack: no fetch completed in 100 cycles");
        end
    endtask

    task automatic wait_stop;
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (halted || fault != 2'b00) got = 1;
        end
        if (!got) begin
            nchk++; nerr++;
            $display("FAIL wait_stop: no halt/fault in 300 cycles");
        end
    endtask

    // ---------------- scenarios ----------------
    logic [31:0] a;
    logic [4:0]  cap;
    int cnt;
    bit done;

    initial begin
        fill_mem(32'hFF00_0000);
        do_reset;
        chk("rst_all_zero", allout, 76'd0);

        // loadi r4,FF then halt
        mem[0] = 32'h0004_00FF;
        set_delay(0);
        start;
        wait_ack(a);
        chk("t1_addr0", a, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_we_c3", rf_we, 1'b0);
        @(negedge clk);
        chk("t1_we_c4", rf_we, 1'b1);
        chk("t1_waddr", rf_waddr, 3'd4);
        chk("t1_imm", imm, 8'hFF);
        chk("t1_imm_sel", imm_sel, 1'b0);
        wait_ack(a);
        chk("t1_addr1", a, 32'h4);
        chk("t1_retired", retired, 16'd1);
        wait_stop;
        chk("t4_halted", halted, 1'b1);
        chk("t4_halt_fault", fault, 2'b00);
        chk("t4_halt_busy", busy, 1'b0);
        chk("t1_r4", rf[4], 8'hFF);

        // small program on the datapath model
        do_reset;
        fill_mem(32'hFF00_0000);
        mem[0] = 32'h0006_00AA;
        mem[1] = 32'h0003_00BB;
        mem[2] = 32'h0105_0603;
        mem[3] = 32'h0904_0703;
        set_delay(-1);
        start;
        cap = '0;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (rf_we && rf_waddr == 3'd4)
                cap = {neg_sel, imm_sel, alu_select};
            if (halted) done = 1;
        end
        chk("t2_halted", done, 1'b1);
        chk("t2_r5", rf[5], 8'h65);
        chk("t2_r4", rf[4], 8'h45);
        chk("t2_sub_ctl", cap, 5'b11_001);
        chk("t2_retired", retired, 16'd4);

        // backward jump at 0x10
        do_reset;
        fill_mem(32'h0000_0000);
        mem[4] = 32'h04FE_0000;
        set_delay(-1);
        start;
        a = 32'hFFFF_FFFF;
        for (int k = 0; k < 8 && a != 32'h10; k++) wait_ack(a);
        chk("t3_at_jump", a, 32'h10);
        chk("t3_ret_before", retired, 16'd4);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (rf_we) cnt++;
        end
        chk("t3_no_we", cnt, 0);
        wait_ack(a);
        chk("t3_target", a, 32'h0C);
        chk("t3_ret_after", retired, 16'd5);
        run = 1'b0;

        // illegal opcode
        do_reset;
        fill_mem(32'hFF00_0000);
        mem[0] = 32'h0700_0000;
        set_delay(0);
        start;
        wait_stop;
        chk("t4_ill_fault", fault, 2'b01);
        chk("t4_ill_busy", busy, 1'b0);
        chk("t4_ill_halted", halted, 1'b0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) cnt++;
        end
        chk("t4_no_req", cnt, 0);

        // fetch timeout: no ack for 16 cycles
        do_reset;
        mem[0] = 32'h0001_0011;
        set_delay(16);
        start;
        cnt = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (imem_req) cnt++;
            if (fault != 2'b00) done = 1;
        end
        chk("t5_req_cycles", cnt, 16);
        chk("t5_fault", fault, 2'b10);
        chk("t5_req_low", imem_req, 1'b0);

        // ack on the 16th cycle still completes normally
        do_reset;
        set_delay(15);
        start;
        wait_ack(a);
        chk("t5_late_addr", a, 32'h0);
        wait_stop;
        chk("t5_late_fault", fault, 2'b00);
        chk("t5_late_ret", retired, 16'd1);
        chk("t5_late_halt", halted, 1'b1);

        // reset while waiting for a fetch
        do_reset;
        set_delay(10);
        start;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        run = 1'b0;
        #1 chk("t6_fetch_rst", allout, 76'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // reset during write-back
        set_delay(0);
        start;
        wait_ack(a);
        chk("t6_addr0", a, 32'h0);
        repeat (3) @(negedge clk);
        chk("t6_in_wb", rf_we, 1'b1);
        #1 reset = 1'b1;
        run = 1'b0;
        #1 chk("t6_wb_rst", allout, 76'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        start;
        wait_ack(a);
        chk("t6_restart", a, 32'h0);

        // randomized run checked every cycle by the model
        do_reset;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            logic [7:0] o;
            r = $urandom;
            case ($urandom_range(0, 11))
                0, 1:    o = 8'h00;
                2, 3:    o = 8'h01;
                4:       o = 8'h02;
                5:       o = 8'h03;
                6, 7:    o = 8'h08;
                8, 9:    o = 8'h09;
                default: o = 8'h04;
            endcase
            mem[i] = {o, r[23:0]};
        end
        set_delay(-1);
        start;
        repeat (3000) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 39) == 0) run = ~run;
        end
        run = 1'b0;
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
